// File: rtl/gpmc_wb_pkg.sv
// Shared constants for the GPMC-to-Wishbone bridge: FSM state codes,
// the read-timeout fill word and default timeout depth.
package gpmc_wb_pkg;
  localparam int GPMC_W = 16;
  localparam logic [GPMC_W-1:0] DEAD_WORD = 16'hDEAD;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ADDR    = 3'd1;
  localparam state_t ST_WR_WAIT = 3'd2;
  localparam state_t ST_WB_WR   = 3'd3;
  localparam state_t ST_RD_WB   = 3'd4;
  localparam state_t ST_RD_HOLD = 3'd5;

  // strobe slots in the synchroniser bank
  localparam int S_CSN  = 0;
  localparam int S_ADVN = 1;
  localparam int S_OEN  = 2;
  localparam int S_WEIN = 3;
  localparam int NUM_STRB = 4;
endpackage

// File: rtl/gpmc_wb_bridge_sync.sv
// SYNC_STAGES-deep synchroniser for one GPMC strobe with registered
// rise/fall pulses; lvl is aligned with the pulses.
module gpmc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    lvl_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~lvl_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & lvl_q;
  end

  // strobes are active-low, so everything idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/gpmc_wb_bridge.sv
// GPMC async muxed AD bus to single Wishbone read/write master.
// Optional ack timeout with sticky bus_error: define GPMC_WB_TIMEOUT_EN.
module gpmc_wb_bridge
  import gpmc_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPMC_W-1:0]     gpmc_ad_in,
  output logic [GPMC_W-1:0]     gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_oen,
  input  logic                  gpmc_wein,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_write,
  output logic                  wbm_cycle,
  input  logic                  wbm_ack,
  output logic                  bus_error
);
  logic [NUM_STRB-1:0] strb_in, strb_lvl, strb_rise, strb_fall;

  assign strb_in[S_CSN]  = gpmc_csn;
  assign strb_in[S_ADVN] = gpmc_advn;
  assign strb_in[S_OEN]  = gpmc_oen;
  assign strb_in[S_WEIN] = gpmc_wein;

  for (genvar gi = 0; gi < NUM_STRB; gi++) begin : g_sync
    gpmc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(reset),
      .d    (strb_in[gi]),
      .lvl  (strb_lvl[gi]),
      .rise (strb_rise[gi]),
      .fall (strb_fall[gi])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{strb_lvl[S_ADVN], strb_rise[S_CSN], strb_fall[S_CSN],
                          strb_fall[S_ADVN], strb_rise[S_OEN]};

  logic csn_hi, oen_hi, wein_hi;
  assign csn_hi  = strb_lvl[S_CSN];
  assign oen_hi  = strb_lvl[S_OEN];
  assign wein_hi = strb_lvl[S_WEIN];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    cyc_q, cyc_d, we_q, we_d;
  logic [GPMC_W-1:0]       ad_out_q, ad_out_d;
  logic                    oe_q, oe_d;
  logic                    discard_q, discard_d;
  logic                    in_wb, tmo_hit;

  assign in_wb = (state_q == ST_WB_WR) || (state_q == ST_RD_WB);

`ifdef GPMC_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  always_comb begin
    tmo_cnt_d = in_wb ? tmo_cnt_q + TW'(1) : '0;
    tmo_hit   = in_wb && !wbm_ack && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    err_d     = err_q | tmo_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus_error = err_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    ad_out_d  = ad_out_q;
    oe_d      = oe_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (!csn_hi && strb_rise[S_ADVN]) begin
          state_d = ST_ADDR;
          addr_d  = gpmc_ad_in[ADDR_WIDTH-1:0];
        end
      end
      ST_ADDR: begin
        if (csn_hi) begin
          state_d = ST_IDLE;
        end else if (strb_fall[S_WEIN]) begin
          state_d = ST_WR_WAIT;
        end else if (strb_fall[S_OEN] && wein_hi) begin
          // wein already low means both strobes active: the write wins
          state_d   = ST_RD_WB;
          cyc_d     = 1'b1;
          we_d      = 1'b0;
          discard_d = 1'b0;
        end else if (strb_rise[S_ADVN]) begin
          addr_d = gpmc_ad_in[ADDR_WIDTH-1:0];
        end
      end
      ST_WR_WAIT: begin
        if (csn_hi) begin
          state_d = ST_IDLE;
        end else if (strb_rise[S_WEIN]) begin
          state_d = ST_WB_WR;
          wdata_d = DATA_WIDTH'(gpmc_ad_in);
          cyc_d   = 1'b1;
          we_d    = 1'b1;
        end
      end
      ST_WB_WR: begin
        if (wbm_ack || tmo_hit) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      ST_RD_WB: begin
        // master gave up on the read while the slave is busy
        if (csn_hi || oen_hi) discard_d = 1'b1;
        if (wbm_ack || tmo_hit) begin
          cyc_d = 1'b0;
          if (discard_q || csn_hi || oen_hi) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_RD_HOLD;
            ad_out_d = wbm_ack ? GPMC_W'(wbm_readdata) : DEAD_WORD;
            oe_d     = 1'b1;
          end
        end
      end
      ST_RD_HOLD: begin
        if (csn_hi || oen_hi) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      ad_out_q  <= '0;
      oe_q      <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      ad_out_q  <= ad_out_d;
      oe_q      <= oe_d;
      discard_q <= discard_d;
    end
  end

  assign wbm_address   = addr_q;
  assign wbm_writedata = wdata_q;
  assign wbm_cycle     = cyc_q;
  assign wbm_write     = we_q;
  assign gpmc_ad_out   = ad_out_q;
  assign gpmc_ad_oe    = oe_q;
endmodule

// File: tb/tb_gpmc_wb_bridge.sv
// Randomised GPMC master + Wishbone slave bench for gpmc_wb_bridge,
// scored against a plain memory model of what the master intended.
module tb_gpmc_wb_bridge;
  localparam int HOLD = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpmc_ad_in, gpmc_ad_out;
  logic        gpmc_ad_oe, gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wein;
  logic [4:0]  wbm_address;
  logic [15:0] wbm_writedata, wbm_readdata;
  logic        wbm_write, wbm_cycle, wbm_ack, bus_error;

  gpmc_wb_bridge dut (
    .clk(clk), .reset(reset),
    .gpmc_ad_in(gpmc_ad_in), .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe),
    .gpmc_csn(gpmc_csn), .gpmc_advn(gpmc_advn), .gpmc_oen(gpmc_oen), .gpmc_wein(gpmc_wein),
    .wbm_address(wbm_address), .wbm_writedata(wbm_writedata), .wbm_readdata(wbm_readdata),
    .wbm_write(wbm_write), .wbm_cycle(wbm_cycle), .wbm_ack(wbm_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [15:0] exp_mem [32];
  logic [15:0] smem [32];

  // slave bookkeeping
  int   start_cnt = 0, done_cnt = 0, wait_n = 0, dly = 0, next_dly = 0;
  bit   busy = 0, hang = 0, stable = 1;
  logic [4:0]  cap_addr;
  logic [15:0] cap_data;
  logic        cap_we;
  logic [4:0]  last_addr;
  logic [15:0] last_data;
  logic        last_we, last_stable;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wishbone slave: acks after next_dly clocks unless hang is set
  initial begin
    wbm_ack = 1'b0;
    wbm_readdata = '0;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (wbm_ack) begin
          wbm_ack = 1'b0;
          busy = 0;
          if (cap_we) smem[cap_addr] = cap_data;
          last_addr = cap_addr; last_data = cap_data;
          last_we = cap_we; last_stable = stable;
          done_cnt++;
        end else if (!wbm_cycle) begin
          busy = 0;
        end else begin
          if (wbm_address !== cap_addr || wbm_writedata !== cap_data || wbm_write !== cap_we)
            stable = 0;
          if (!hang && wait_n == dly) wbm_ack = 1'b1;
          else wait_n++;
        end
      end else if (wbm_cycle) begin
        start_cnt++;
        busy = 1; stable = 1; wait_n = 0; dly = next_dly;
        cap_addr = wbm_address; cap_data = wbm_writedata; cap_we = wbm_write;
        wbm_readdata = smem[wbm_address];
        if (!hang && dly == 0) wbm_ack = 1'b1;
      end
    end
  end

  task automatic gpmc_addr(input logic [4:0] a);
    gpmc_csn = 1'b0;
    gpmc_ad_in = {11'($urandom), a};
    gpmc_advn = 1'b0;
    clks(HOLD);
    gpmc_advn = 1'b1;
    clks(HOLD);
  endtask

  task automatic gpmc_write(input logic [4:0] a, input logic [15:0] d, input bit both);
    int n0, c0;
    n0 = start_cnt; c0 = done_cnt;
    gpmc_addr(a);
    gpmc_ad_in = d;
    gpmc_wein = 1'b0;
    if (both) gpmc_oen = 1'b0;
    clks(HOLD);
    gpmc_wein = 1'b1;
    clks(HOLD);
    for (int i = 0; i < 40 && done_cnt == c0; i++) clks(1);
    chk("wr_done", done_cnt - c0, 1);
    chk("wr_we", last_we, 1);
    chk("wr_addr", last_addr, a);
    chk("wr_data", last_data, d);
    chk("wr_stable", last_stable, 1);
    exp_mem[a] = d;
    gpmc_oen = 1'b1;
    gpmc_csn = 1'b1;
    clks(HOLD);
    chk("wr_once", start_cnt - n0, 1);
  endtask

  task automatic gpmc_read(input logic [4:0] a);
    int n0;
    n0 = start_cnt;
    gpmc_addr(a);
    gpmc_ad_in = 16'($urandom);
    gpmc_oen = 1'b0;
    for (int i = 0; i < 40 && !gpmc_ad_oe; i++) clks(1);
    chk("rd_oe", gpmc_ad_oe, 1);
    chk("rd_data", gpmc_ad_out, exp_mem[a]);
    chk("rd_we", last_we, 0);
    clks(2);
    chk("rd_oe_held", gpmc_ad_oe, 1);
    gpmc_oen = 1'b1;
    clks(HOLD);
    chk("rd_oe_off", gpmc_ad_oe, 0);
    gpmc_csn = 1'b1;
    clks(HOLD);
    chk("rd_once", start_cnt - n0, 1);
  endtask

  task automatic gpmc_abort(input logic [4:0] a);
    int n0;
    n0 = start_cnt;
    gpmc_addr(a);
    gpmc_csn = 1'b1;
    clks(HOLD);
    chk("abort_nocyc", start_cnt - n0, 0);
    chk("abort_oe", gpmc_ad_oe, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = 16'(i * 16'h0101 + 16'h5A00);
      smem[i] = exp_mem[i];
    end
    reset = 1'b0;
    gpmc_csn = 1'b1; gpmc_advn = 1'b1; gpmc_oen = 1'b1; gpmc_wein = 1'b1;
    gpmc_ad_in = '0;
    clks(3);
    chk("rst_ad_out", gpmc_ad_out, 0);
    chk("rst_oe", gpmc_ad_oe, 0);
    chk("rst_addr", wbm_address, 0);
    chk("rst_wdata", wbm_writedata, 0);
    chk("rst_we", wbm_write, 0);
    chk("rst_cyc", wbm_cycle, 0);
    chk("rst_err", bus_error, 0);
    reset = 1'b1;
    clks(HOLD);

    // directed cases
    next_dly = 0;
    gpmc_write(5'h00, 16'h000A, 0);
    chk("led_nibble", smem[0][3:0], 4'hA);
    gpmc_read(5'h00);
    next_dly = 5;
    gpmc_write(5'h11, 16'hBEEF, 0);
    next_dly = 1;
    gpmc_abort(5'h02);
    gpmc_write(5'h03, 16'h1234, 0);
    gpmc_read(5'h03);
    gpmc_write(5'h07, 16'hC0DE, 1);
    gpmc_read(5'h07);

    // csn released while the Wishbone read is in flight: data discarded
    begin
      int c0;
      c0 = done_cnt;
      next_dly = 10;
      gpmc_addr(5'h04);
      gpmc_oen = 1'b0;
      for (int i = 0; i < 40 && !wbm_cycle; i++) clks(1);
      gpmc_csn = 1'b1;
      for (int i = 0; i < 40 && done_cnt == c0; i++) clks(1);
      chk("disc_done", done_cnt - c0, 1);
      clks(HOLD);
      chk("disc_oe", gpmc_ad_oe, 0);
      gpmc_oen = 1'b1;
      clks(HOLD);
    end

    // reset pulsed while in RD_WB
    hang = 1;
    gpmc_addr(5'h11);
    gpmc_oen = 1'b0;
    for (int i = 0; i < 40 && !wbm_cycle; i++) clks(1);
    chk("rstmid_cyc_pre", wbm_cycle, 1);
    clks(2);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_cyc", wbm_cycle, 0);
    chk("rstmid_oe", gpmc_ad_oe, 0);
    chk("rstmid_addr", wbm_address, 0);
    chk("rstmid_out", gpmc_ad_out, 0);
    clks(2);
    gpmc_oen = 1'b1; gpmc_csn = 1'b1;
    hang = 0;
    reset = 1'b1;
    clks(HOLD);
    next_dly = 2;
    gpmc_read(5'h11);

    // randomised traffic
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [4:0] a;
      op = int'($urandom_range(0, 99));
      a = 5'($urandom);
      next_dly = int'($urandom_range(0, 5));
      if (op < 50) gpmc_write(a, 16'($urandom), op < 5);
      else if (op < 85) gpmc_read(a);
      else gpmc_abort(a);
    end

`ifdef GPMC_WB_TIMEOUT_EN
    hang = 1;
    gpmc_addr(5'h09);
    gpmc_oen = 1'b0;
    for (int i = 0; i < 60 && !gpmc_ad_oe; i++) clks(1);
    chk("tmo_oe", gpmc_ad_oe, 1);
    chk("tmo_data", gpmc_ad_out, 16'hDEAD);
    chk("tmo_err", bus_error, 1);
    gpmc_oen = 1'b1; gpmc_csn = 1'b1;
    clks(HOLD);
    hang = 0;
    next_dly = 0;
    gpmc_write(5'h09, 16'h4321, 0);
    chk("tmo_err_sticky", bus_error, 1);
    reset = 1'b0;
    clks(2);
    chk("tmo_err_clr", bus_error, 0);
    reset = 1'b1;
    clks(HOLD);
`else
    chk("no_err", bus_error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
